// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Purpose  : NUM_CH independent square-wave dividers running from basys_clk.
//            Each channel has its own runtime-programmable half-period H,
//            which gives an output period of 2*(H+1) cycles at 50% duty.
//            A one-cycle tick marks every rising edge of a channel's output.
//            New half-periods arrive through a valid/ready port. They wait in
//            a per-channel shadow register and are applied without glitches.
//
// Ports    : basys_clk  in   system clock, all logic on its rising edge
//            reset_n    in   asynchronous active-low reset
//            en         in   [NUM_CH]  per-channel run enable
//            sync       in   phase-align strobe (CLKDIV_PHASE_SYNC_EN only)
//            cfg_valid  in   config request
//            cfg_ready  out  config accept (combinational)
//            cfg_ch     in   [CH_W]   target channel of the request
//            cfg_half   in   [CNT_W]  new half-period value
//            clk_out    out  [NUM_CH] divided square wave, registered
//            tick       out  [NUM_CH] pulse on each 0->1 of clk_out, registered
//
// Options  : `define CLKDIV_PHASE_SYNC_EN adds the sync input. When sync is
//            high at an edge, every channel restarts from phase zero at the
//            same time.
//
// Revision : 1.0  initial multi-channel release (replaces fixed 400 Hz divider)
// ============================================================================
module clk_div_multi #(
  parameter int                 NUM_CH       = 4,
  parameter int                 CH_W         = 2,
  parameter int                 CNT_W        = 32,
  parameter logic [CNT_W-1:0]   DEFAULT_HALF = CNT_W'(124999)
) (
  input  logic                basys_clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   en,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                sync,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_half,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  // Shadow-occupied flags gathered from every channel, plus handshake decode.
  logic [NUM_CH-1:0] w_pend_valid;
  logic              w_cfg_ready;
  logic [NUM_CH-1:0] w_xfer;

  // A channel with a reload already waiting cannot take another one.
  // Out-of-range channel numbers are always accepted and then discarded,
  // so a bad address can never stall the config port.
  always_comb begin
    w_cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        w_cfg_ready = ~w_pend_valid[i];
      end
    end
  end

  assign cfg_ready = w_cfg_ready;

  // Per-channel write strobe into the shadow register. No channel matches an
  // out-of-range cfg_ch, which gives the discard behaviour.
  always_comb begin
    w_xfer = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_xfer[i] = cfg_valid && w_cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk;
    logic             r_tick;
    logic             w_wrap;

    // The counter stays within 0..r_half. r_half only changes at a wrap
    // (count returns to 0) or while the counter is held at 0, so equality is
    // enough and no count can ever be left stranded above the limit.
    assign w_wrap = (r_count == r_half);

    always_ff @(posedge basys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_count      <= '0;
        r_half       <= DEFAULT_HALF;
        r_pend       <= '0;
        r_pend_valid <= 1'b0;
        r_clk        <= 1'b0;
        r_tick       <= 1'b0;
      end else begin
`ifdef CLKDIV_PHASE_SYNC_EN
        // Phase alignment overrides both enable and wrap. Nothing is running,
        // so a waiting reload can be applied safely.
        if (sync) begin
          r_count <= '0;
          r_clk   <= 1'b0;
          r_tick  <= 1'b0;
          if (r_pend_valid) begin
            r_half       <= r_pend;
            r_pend_valid <= 1'b0;
          end
        end else
`endif
        if (!en[gi]) begin
          // Held idle. A reload lands immediately because no period is in
          // progress.
          r_count <= '0;
          r_clk   <= 1'b0;
          r_tick  <= 1'b0;
          if (r_pend_valid) begin
            r_half       <= r_pend;
            r_pend_valid <= 1'b0;
          end
        end else if (w_wrap) begin
          // End of a half-period. This is the only point where a running
          // channel swaps in a new half-period, so the period in progress
          // always finishes with the old value.
          r_count <= '0;
          r_clk   <= ~r_clk;
          r_tick  <= ~r_clk;
          if (r_pend_valid) begin
            r_half       <= r_pend;
            r_pend_valid <= 1'b0;
          end
        end else begin
          r_count <= r_count + CNT_W'(1);
          r_tick  <= 1'b0;
        end

        // A transfer needs r_pend_valid low beforehand, so it never conflicts
        // with the clears above. If it coincides with a wrap, the value only
        // reaches the shadow here and takes effect at the following wrap.
        if (w_xfer[gi]) begin
          r_pend       <= cfg_half;
          r_pend_valid <= 1'b1;
        end
      end
    end

    assign w_pend_valid[gi] = r_pend_valid;
    assign clk_out[gi]      = r_clk;
    assign tick[gi]         = r_tick;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Purpose  : Self-checking bench for clk_div_multi. A reference model driven
//            by event timestamps predicts each channel's next toggle as an
//            absolute cycle number. It is compared every cycle with clk_out,
//            tick and cfg_ready, under both directed and random stimulus.
//            DEFAULT_HALF is reduced here so that the default-period
//            scenario fits in a short run.
// Revision : 1.0  initial
// ============================================================================
module tb_clk_div_multi;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 3;
  localparam int CNT_W    = 16;
  localparam int DEF_HALF = 24;

  logic              basys_clk;
  logic              reset_n;
  logic [NUM_CH-1:0] en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic              sync;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: absolute cycle index of each channel's next toggle.
  longint            cyc;
  int unsigned       m_half [NUM_CH];
  int unsigned       m_pend [NUM_CH];
  longint            m_next [NUM_CH];
  logic [NUM_CH-1:0] m_pv;
  logic [NUM_CH-1:0] m_run;
  logic [NUM_CH-1:0] m_lvl;
  logic [NUM_CH-1:0] m_tick;

  clk_div_multi #(
    .NUM_CH       (NUM_CH),
    .CH_W         (CH_W),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (CNT_W'(DEF_HALF))
  ) dut (
    .basys_clk (basys_clk),
    .reset_n   (reset_n),
    .en        (en),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync      (sync),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial basys_clk = 1'b0;
  always #5 basys_clk = ~basys_clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_half[c] = DEF_HALF;
      m_pend[c] = 0;
      m_next[c] = 0;
    end
    m_pv = '0; m_run = '0; m_lvl = '0; m_tick = '0;
  endtask

  function automatic logic model_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return ~m_pv[int'(cfg_ch)];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic rdy;
    logic s;
    int   idx;
    rdy = model_ready();
    s   = 1'b0;
`ifdef CLKDIV_PHASE_SYNC_EN
    s = sync;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      m_tick[c] = 1'b0;
      if (s || !en[c]) begin
        m_lvl[c] = 1'b0;
        m_run[c] = 1'b0;
        if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 1'b0; end
      end else begin
        // First enabled edge: the first toggle comes H edges later.
        if (!m_run[c]) begin
          m_run[c]  = 1'b1;
          m_next[c] = cyc + longint'(m_half[c]);
        end
        if (cyc == m_next[c]) begin
          m_lvl[c]  = ~m_lvl[c];
          m_tick[c] = m_lvl[c];
          if (m_pv[c]) begin m_half[c] = m_pend[c]; m_pv[c] = 1'b0; end
          m_next[c] = cyc + longint'(m_half[c]) + 1;
        end
      end
    end
    idx = int'(cfg_ch);
    if (cfg_valid && rdy && idx < NUM_CH) begin
      m_pend[idx] = int'(cfg_half);
      m_pv[idx]   = 1'b1;
    end
    cyc++;
  endtask

  // Called just after a falling edge with inputs already set. Ends on the
  // next falling edge.
  task automatic step();
    #1;
    check_value("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
    @(posedge basys_clk);
    model_edge();
    #1;
    check_value("clk_out", 32'(clk_out), 32'(m_lvl));
    check_value("tick", 32'(tick), 32'(m_tick));
    @(negedge basys_clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg_send(input int ch, input int half);
    logic rdy;
    logic done;
    done      = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_half  = CNT_W'(half);
    for (int k = 0; k < 100 && !done; k++) begin
      rdy = model_ready();
      step();
      if (rdy) done = 1'b1;
    end
    cfg_valid = 1'b0;
    check_value("cfg_accepted", 32'(done), 32'd1);
  endtask

  // Measure one full output period and its high time on a channel's outputs.
  task automatic measure_period(input int ch, input int exp_per);
    logic seen;
    int   per;
    int   hi;
    logic stop;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      if (tick[ch]) seen = 1'b1;
    end
    check_value("tick_seen", 32'(seen), 32'd1);
    if (seen) begin
      per = 0; hi = 1; stop = 1'b0;
      for (int k = 0; k < 200 && !stop; k++) begin
        step();
        per++;
        if (tick[ch]) stop = 1'b1;
        else if (clk_out[ch]) hi++;
      end
      check_value("period", 32'(per), 32'(exp_per));
      check_value("high_time", 32'(hi), 32'(exp_per / 2));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rdy;
    logic seen_hi;
    int   idx;
    reset_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync = 1'b0;
`endif
    cyc = 0;
    model_reset();
    repeat (3) @(negedge basys_clk);
    check_value("rst_clk_out", 32'(clk_out), 32'd0);
    check_value("rst_tick", 32'(tick), 32'd0);
    check_value("rst_ready", 32'(cfg_ready), 32'd1);
    reset_n = 1'b1;

    // Channel 0 at the default half-period. Other channels stay low.
    en = 4'b0001;
    measure_period(0, 2 * (DEF_HALF + 1));
    run(10);

    // Channel 1 loaded while disabled, then enabled: period 8, high 4.
    cfg_send(1, 3);
    run(2);
    en[1] = 1'b1;
    measure_period(1, 8);
    run(5);

    // Channel 2 at H=9. Reload to H=1 mid-half-period, then a second load
    // must stall until the first one has been consumed at a wrap.
    cfg_send(2, 9);
    run(2);
    en[2] = 1'b1;
    run(4);
    cfg_send(2, 1);
    cfg_valid = 1'b1; cfg_ch = CH_W'(2); cfg_half = CNT_W'(5);
    #1;
    check_value("ready_stall", 32'(cfg_ready), 32'd0);
    cfg_send(2, 5);
    run(30);

    // Drop en[0] while its output is high: low next cycle, no tick.
    seen_hi = 1'b0;
    for (int k = 0; k < 200 && !seen_hi; k++) begin
      step();
      if (m_lvl[0]) seen_hi = 1'b1;
    end
    check_value("ch0_high_reached", 32'(seen_hi), 32'd1);
    run(3);
    en[0] = 1'b0;
    step();
    check_value("drop_clk0", 32'(clk_out[0]), 32'd0);
    check_value("drop_tick0", 32'(tick[0]), 32'd0);
    run(5);
    en[0] = 1'b1;
    run(60);

    // Half-period 0 toggles every cycle. Out-of-range channels are discarded.
    cfg_send(3, 0);
    en[3] = 1'b1;
    measure_period(3, 2);
    cfg_send(6, 3);
    cfg_send(7, 1);
    run(10);

    // Asynchronous reset in the middle of activity.
    cfg_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_value("async_rst_clk_out", 32'(clk_out), 32'd0);
    check_value("async_rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge basys_clk);
    reset_n = 1'b1;
    run(60);

`ifdef CLKDIV_PHASE_SYNC_EN
    // Phase alignment, with an out-of-range request in the same cycle.
    en = '0;
    step();
    cfg_send(0, 2);
    cfg_send(3, 5);
    run(3);
    en = 4'b1001;
    run(17);
    sync = 1'b1; cfg_valid = 1'b1; cfg_ch = CH_W'(7); cfg_half = CNT_W'(9);
    step();
    sync = 1'b0; cfg_valid = 1'b0;
    check_value("sync_clk_out", 32'(clk_out), 32'd0);
    run(12);
`endif

    // Random mix of enables, reloads and out-of-range requests.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 39) == 0) begin
        idx = int'($urandom_range(0, NUM_CH - 1));
        en[idx] = ~en[idx];
      end
      if (!cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'($urandom_range(0, 7));
        cfg_half  = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
      end
`ifdef CLKDIV_PHASE_SYNC_EN
      sync = ($urandom_range(0, 59) == 0);
`endif
      rdy = model_ready();
      step();
      if (cfg_valid && rdy) cfg_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider; successor to the team's fixed single-output 400 Hz divider.
- Generates NUM_CH independent square-wave enables/clocks from basys_clk (100 MHz), each with a runtime-programmable half-period.
- Per-channel enable; one-cycle tick per output period; glitch-free reload through a valid/ready config port.
- Feeds display multiplexing, debounce sampling and audio/tone blocks.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH.
- CNT_W, 32, counter and half-period width.
- DEFAULT_HALF, 124999, reset half-period for every channel (400 Hz at 100 MHz).

Ports:
- basys_clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; combinational from cfg_ch and pend_valid.
- cfg_ch  in  CH_W  target channel.
- cfg_half  in  CNT_W  new half-period value H; output period = 2*(H+1) cycles.
- clk_out  out  NUM_CH  divided square wave per channel, registered.
- tick  out  NUM_CH  one-cycle pulse on each 0->1 transition of clk_out, registered.

Behaviour:
- Reset (async assert, sync-safe deassert irrelevant here; synchronised externally):
  - count=0, clk_out=0, tick=0 for every channel.
  - half_q=DEFAULT_HALF, pend_valid=0 for every channel.
- Per-channel state: count[CNT_W], active half_q, shadow pend_q, pend_valid.
- Counting, en[i]=1: count increments each cycle.
  - When count==half_q: count<=0 and clk_out toggles.
  - Toggle occurs every half_q+1 cycles, giving a 50% duty cycle.
- tick: asserted in the same cycle clk_out becomes 1; exactly one tick per output period.
- Disabled, en[i]=0: next cycle count<=0, clk_out<=0, tick<=0; channel held there.
  - Re-enable: count starts from 0; first rising edge of clk_out occurs half_q+1 cycles after the first enabled edge.
  - en falling mid-period truncates the period; no tick is emitted.
- Config handshake:
  - Transfer occurs on cfg_valid && cfg_ready at a clock edge.
  - cfg_ready = !pend_valid[cfg_ch] for a valid channel.
  - On transfer: pend_q<=cfg_half, pend_valid<=1.
- Reload application (glitch-free):
  - Enabled channel: pend_q is copied to half_q only at a wrap (count==half_q), and pend_valid clears in that cycle. The period in progress always completes with the old value.
  - Disabled channel: pend_q is applied on the cycle after acceptance.
- Simultaneous transfer and wrap on the same channel: the new value goes to the shadow and is applied at the following wrap, not the current one.
- cfg_ch >= NUM_CH: cfg_ready=1, request accepted and discarded, no state change.
- cfg_half=0: legal; clk_out toggles every cycle (basys_clk/2), tick every 2 cycles.
- Counter never exceeds half_q. It cannot, because half_q only changes at wrap or while count is held at 0.

Optional Feature:
- Macro: CLKDIV_PHASE_SYNC_EN.
- Defined: adds input port sync (1 bit). When sync=1 at an edge, all channels at once take count<=0, clk_out<=0, tick<=0, and any pending reload is applied. This aligns all channels' phases.
  - sync takes priority over wrap and en.
  - A config transfer in the same cycle lands in the shadow after the sync.
- Undefined: no sync port and no phase-alignment logic; channels are phase-related only through reset.

Test Plan:
- Reset release, en=4'b0001, channel 0 default: clk_out[0] rises 125000 cycles after en. Period is 250000 cycles; one tick per period; other channels stay 0.
- Load ch1 H=3 while disabled, then en[1]=1: clk_out[1] has period 8 cycles, high 4 / low 4. tick[1] appears every 8 cycles, coincident with the rise.
- Ch2 running with H=9; load H=1 at count=4: the current half-period completes at 10 cycles, then toggles every 2 cycles. No short or glitched pulse.
- Second load to ch2 while pend_valid=1: cfg_ready=0 and the request stalls until the wrap clears pend_valid. Then it is accepted.
- Drop en[0] mid-high-phase: clk_out[0]=0 the next cycle, no tick. Re-enable: full first half-period.
- CLKDIV_PHASE_SYNC_EN, ch0 H=2 and ch3 H=5 running, pulse sync: both outputs are 0 the next cycle. The first rises occur at 3 and 6 cycles after sync; cfg_ch=7 (with CH_W=3, NUM_CH=4) is accepted and ignored.
